// File: rtl/booth_divider.sv
// Sequential signed divider: |Dvd| / |Dvs| by restoring division, one quotient
// bit per clock, then sign fix-up. Optional overflow/zero-divide handling: OVF_CHECK_EN.
module booth_divider #(
    parameter int DVS_W = 8,
    parameter int DVD_W = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             St,
    input  logic [DVD_W-1:0] Dvd,
    input  logic [DVS_W-1:0] Dvs,
    output logic             Ready,
    output logic [DVS_W-1:0] Quot,
    output logic [DVS_W-1:0] Rem,
    output logic             Ovf
);

    localparam int               CNT_W    = $clog2(DVD_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DVD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [CNT_W-1:0] r_cnt;
    // Dividend magnitude shifts out of the top while quotient bits enter the bottom.
    logic [DVD_W-1:0] r_acc;
    logic [DVS_W-1:0] r_prem;
    logic [DVS_W-1:0] r_dvs;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_ready;
    logic [DVS_W-1:0] r_quot;
    logic [DVS_W-1:0] r_rem;
    logic             r_ovf;

    logic             w_accept;
    logic             w_early_exit;
    logic [DVD_W-1:0] w_dvd_mag;
    logic [DVS_W-1:0] w_dvs_mag;
    logic [DVS_W:0]   w_shift;
    logic [DVS_W+1:0] w_diff;
    logic             w_q_bit;
    logic [DVS_W-1:0] w_prem_next;
    logic [DVS_W-1:0] w_fix_quot;
    logic [DVS_W-1:0] w_fix_rem;
    logic             w_fix_ovf;

`ifdef OVF_CHECK_EN
    logic             r_dz;
    logic             w_dvs_zero;
    logic             w_q_ovf;
    logic [DVS_W-1:0] w_sat;

    assign w_dvs_zero   = (Dvs == '0);
    assign w_early_exit = w_dvs_zero;
    // Negative results may reach 2^(DVS_W-1); positive ones stop one short.
    assign w_q_ovf = (|r_acc[DVD_W-1:DVS_W]) ||
                     (r_acc[DVS_W-1] && (!r_sign_q || (r_acc[DVS_W-2:0] != '0)));
    assign w_sat   = r_sign_q ? {1'b1, {(DVS_W-1){1'b0}}} : {1'b0, {(DVS_W-1){1'b1}}};
`else
    assign w_early_exit = 1'b0;
`endif

    assign w_accept  = (r_state == S_IDLE) && St;
    assign w_dvd_mag = Dvd[DVD_W-1] ? (DVD_W'(0) - Dvd) : Dvd;
    assign w_dvs_mag = Dvs[DVS_W-1] ? (DVS_W'(0) - Dvs) : Dvs;

    // Partial remainder stays below |Dvs|, so the shifted value needs one extra bit.
    assign w_shift     = {r_prem, r_acc[DVD_W-1]};
    assign w_diff      = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_q_bit     = ~w_diff[DVS_W+1];
    assign w_prem_next = w_q_bit ? w_diff[DVS_W-1:0] : w_shift[DVS_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fix_quot   = r_sign_q ? (DVS_W'(0) - r_acc[DVS_W-1:0]) : r_acc[DVS_W-1:0];
        w_fix_rem    = r_sign_r ? (DVS_W'(0) - r_prem) : r_prem;
        w_fix_ovf    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (St) begin
                    w_state_next = w_early_exit ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
`ifdef OVF_CHECK_EN
        if (r_dz) begin
            w_fix_quot = w_sat;
            w_fix_rem  = '0;
            w_fix_ovf  = 1'b1;
        end else if (w_q_ovf) begin
            w_fix_quot = w_sat;
            w_fix_ovf  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_prem   <= '0;
            r_dvs    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_ready  <= 1'b1;
            r_quot   <= '0;
            r_rem    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= '0;
                        r_acc    <= w_dvd_mag;
                        r_prem   <= '0;
                        r_dvs    <= w_dvs_mag;
                        r_sign_q <= Dvd[DVD_W-1] ^ Dvs[DVS_W-1];
                        r_sign_r <= Dvd[DVD_W-1];
                        r_ready  <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_acc  <= {r_acc[DVD_W-2:0], w_q_bit};
                    r_prem <= w_prem_next;
                    r_cnt  <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_quot  <= w_fix_quot;
                    r_rem   <= w_fix_rem;
                    r_ovf   <= w_fix_ovf;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef OVF_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dz <= 1'b0;
        end else if (w_accept) begin
            r_dz <= w_dvs_zero;
        end
    end
`endif

    assign Ready = r_ready;
    assign Quot  = r_quot;
    assign Rem   = r_rem;
    assign Ovf   = r_ovf;

endmodule
